// File: rtl/io_stream_loader_pkg.sv
// Shared types, default constants and parameter sanity check for the
// GPU-to-RAM stream loader.
package io_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    FINISH  = 2'd3
  } state_t;

  localparam int DEF_DIN_W        = 4;
  localparam int DEF_WORD_W       = 16;
  localparam int DEF_ADDR_W       = 16;
  localparam int DEF_IMG_BASE     = 0;
  localparam int DEF_FILT_BASE    = 32768;
  localparam int DEF_REGION_DEPTH = 32768;

  // True when a word splits into whole chunks and one region fits the address space.
  function automatic bit params_ok(int din_w, int word_w, int addr_w, int depth);
    longint cap;
    cap = longint'(1) << addr_w;
    return (din_w > 0) && (word_w >= din_w) && ((word_w % din_w) == 0) &&
           (depth > 0) && (longint'(depth) <= cap);
  endfunction

endpackage

// File: rtl/io_stream_loader_if.sv
// GPU-side handshake plus RAM write port of the stream loader.
interface io_stream_loader_if #(
  parameter int DIN_W  = 4,
  parameter int WORD_W = 16,
  parameter int ADDR_W = 16
);
  logic              interrupt;
  logic              load;
  logic              cnn;
  logic [DIN_W-1:0]  datain;
  logic              din_valid;
  logic              ready;
  logic [ADDR_W-1:0] memAdress;
  logic [WORD_W-1:0] memData;
  logic              RamEnable;
  logic              done;
  logic              busy;
  logic [ADDR_W-1:0] word_count;
  logic              partial;
  logic              overflow;

  // The loader side.
  modport slave (
    input  interrupt, load, cnn, datain, din_valid,
    output ready, memAdress, memData, RamEnable, done, busy,
           word_count, partial, overflow
  );

  // The GPU / environment side.
  modport master (
    output interrupt, load, cnn, datain, din_valid,
    input  ready, memAdress, memData, RamEnable, done, busy,
           word_count, partial, overflow
  );
endinterface

// File: rtl/io_stream_loader_chunk_packer.sv
// Shift register that packs DIN_W-bit chunks MSB-first into one WORD_W-bit
// word, counts chunks, and zero-pads a short final word on request.
module chunk_packer #(
  parameter int DIN_W  = 4,
  parameter int WORD_W = 16,
  localparam int N     = WORD_W / DIN_W,
  localparam int CW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift,
  input  logic              pad,
  input  logic [DIN_W-1:0]  datain,
  output logic [WORD_W-1:0] word,
  output logic [CW-1:0]     count,
  output logic              complete
);

  logic [WORD_W-1:0] word_q;
  logic [CW-1:0]     count_q;

  assign complete = shift && (int'(count_q) == N - 1);
  assign word     = word_q;
  assign count    = count_q;

  // Shift chunks in, or push zeros into the unfilled low chunks when the stream ends early.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q  <= '0;
      count_q <= '0;
    end else if (clear) begin
      word_q  <= '0;
      count_q <= '0;
    end else if (shift) begin
      word_q <= (word_q << DIN_W) | WORD_W'(datain);
      if (!complete) begin
        count_q <= count_q + CW'(1);
      end
    end else if (pad) begin
      word_q <= word_q << (DIN_W * (N - int'(count_q)));
    end
  end

endmodule

// File: rtl/io_stream_loader.sv
// Loads a chunk stream from the GPU, packs it into RAM words and writes them
// sequentially into the image or filter region, stopping at the region end.
module io_stream_loader
  import io_pkg::*;
#(
  parameter int DIN_W        = DEF_DIN_W,
  parameter int WORD_W       = DEF_WORD_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int IMG_BASE     = DEF_IMG_BASE,
  parameter int FILT_BASE    = DEF_FILT_BASE,
  parameter int REGION_DEPTH = DEF_REGION_DEPTH,
  localparam int N           = WORD_W / DIN_W,
  localparam int CW          = (N > 1) ? $clog2(N) : 1
) (
  input logic              clk,
  input logic              rst,
  io_stream_loader_if.slave bus
);

  generate
    if (!params_ok(DIN_W, WORD_W, ADDR_W, REGION_DEPTH)) begin : g_bad_params
      $error("io_stream_loader: WORD_W must be a multiple of DIN_W and REGION_DEPTH <= 2**ADDR_W");
    end
  endgenerate

  localparam logic [ADDR_W-1:0] IMG_ADDR  = ADDR_W'(IMG_BASE);
  localparam logic [ADDR_W-1:0] FILT_ADDR = ADDR_W'(FILT_BASE);
  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W+1)'(REGION_DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, wc_q, hold_addr_q;
  logic [WORD_W-1:0] hold_data_q;
  logic              partial_q, overflow_q, pend_q;
  logic              start, pad, do_write, accept, last_word;
  logic [WORD_W-1:0] word;
  logic [CW-1:0]     count;
  logic              complete;

  assign accept    = (state_q == COLLECT) && bus.din_valid && bus.load;
  assign last_word = ({1'b0, wc_q} + 1'b1) == DEPTH_W;

  chunk_packer #(.DIN_W(DIN_W), .WORD_W(WORD_W)) u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear    (start | do_write),
    .shift    (accept),
    .pad      (pad),
    .datain   (bus.datain),
    .word     (word),
    .count    (count),
    .complete (complete)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state decode and the one-cycle control strobes.
  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    pad      = 1'b0;
    do_write = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.interrupt) begin
          start   = 1'b1;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (complete) begin
          state_d = WRITE;
        end else if (!bus.load) begin
          if (count == '0) begin
            state_d = FINISH;
          end else begin
            pad     = 1'b1;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        do_write = 1'b1;
        if (last_word || pend_q) state_d = FINISH;
        else                     state_d = COLLECT;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transfer bookkeeping: pointer, word count, sticky flags and held RAM outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= '0;
      wc_q        <= '0;
      partial_q   <= 1'b0;
      overflow_q  <= 1'b0;
      pend_q      <= 1'b0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
    end else begin
      if (start) begin
        ptr_q      <= bus.cnn ? FILT_ADDR : IMG_ADDR;
        wc_q       <= '0;
        partial_q  <= 1'b0;
        overflow_q <= 1'b0;
        pend_q     <= 1'b0;
      end
      if (pad) begin
        partial_q <= 1'b1;
        pend_q    <= 1'b1;
      end
      if (do_write) begin
        ptr_q       <= ptr_q + 1'b1;
        wc_q        <= wc_q + 1'b1;
        hold_addr_q <= ptr_q;
        hold_data_q <= word;
        if (last_word) overflow_q <= 1'b1;
      end
    end
  end

  assign bus.ready      = (state_q == COLLECT);
  assign bus.RamEnable  = (state_q == WRITE);
  assign bus.done       = (state_q == FINISH);
  assign bus.busy       = (state_q != IDLE);
  assign bus.memAdress  = (state_q == WRITE) ? ptr_q : hold_addr_q;
  assign bus.memData    = (state_q == WRITE) ? word : hold_data_q;
  assign bus.word_count = wc_q;
  assign bus.partial    = partial_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_io_stream_loader.sv
// Self-checking bench for io_stream_loader with a small region (4 words) so
// the overflow stop is reachable; expectations come from a word-level model.
module tb_io_stream_loader;

  localparam int N     = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  io_stream_loader_if #(.DIN_W(4), .WORD_W(16), .ADDR_W(16)) bus ();

  io_stream_loader #(.REGION_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] wr_q[$];
  int          done_cnt = 0;
  int          rdy_wr   = 0;

  // Record every RAM write as {addr,data}, done pulses, and ready seen during a write.
  always @(negedge clk) begin
    if (bus.RamEnable) begin
      wr_q.push_back({bus.memAdress, bus.memData});
      if (bus.ready) rdy_wr++;
    end
    if (bus.done) done_cnt++;
  end

  logic [3:0]  stim[$];
  logic [31:0] exp_q[$];
  logic [15:0] exp_wc;
  bit          exp_partial, exp_ovf;
  int          exp_acc;
  logic [31:0] obs_q[$];
  int          obs_acc, obs_done;

  // Word-level reference: group chunks by N, zero-fill the tail, truncate at DEPTH.
  function automatic void model(input bit c);
    int n, words, written;
    logic [15:0] data, base;
    n       = stim.size();
    words   = (n + N - 1) / N;
    written = (words > DEPTH) ? DEPTH : words;
    base    = c ? 16'h8000 : 16'h0000;
    exp_q.delete();
    for (int w = 0; w < written; w++) begin
      data = 16'h0;
      for (int k = 0; k < N; k++) begin
        data = data << 4;
        if (w * N + k < n) data = data | {12'h0, stim[w * N + k]};
      end
      exp_q.push_back({base + 16'(w), data});
    end
    exp_wc      = 16'(written);
    exp_ovf     = (words >= DEPTH);
    exp_partial = ((n % N) != 0) && (words <= DEPTH);
    exp_acc     = (words > DEPTH) ? DEPTH * N : n;
  endfunction

  // Drive one transfer of stim; records writes, accepted chunks and done pulses.
  task automatic run_transfer(input bit c, input int gap, input bit drop_last, input bit irq_mid);
    int  w0, d0;
    bit  got, aborted;
    w0 = wr_q.size();
    d0 = done_cnt;
    obs_acc = 0;
    aborted = 1'b0;
    @(posedge clk); #1;
    bus.cnn = c; bus.interrupt = 1'b1; bus.load = 1'b1;
    @(posedge clk); #1;
    bus.interrupt = 1'b0;
    for (int i = 0; i < stim.size() && !aborted; i++) begin
      bus.datain = stim[i];
      bus.din_valid = 1'b1;
      if (irq_mid && i == 1) bus.interrupt = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 12 && !got && !aborted; t++) begin
        @(negedge clk);
        if (done_cnt != d0) aborted = 1'b1;
        else if (bus.ready) begin
          @(posedge clk); #1;
          got = 1'b1;
        end
      end
      bus.interrupt = 1'b0;
      if (got) begin
        obs_acc++;
        bus.din_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end else begin
        aborted = 1'b1;
      end
    end
    if (drop_last) begin
      bus.datain = 4'($urandom_range(1, 15));
      bus.din_valid = 1'b1;
    end
    bus.load = 1'b0;
    for (int t = 0; t < 30 && done_cnt == d0; t++) @(negedge clk);
    bus.din_valid = 1'b0;
    @(posedge clk); #1;
    obs_q.delete();
    for (int i = w0; i < wr_q.size(); i++) obs_q.push_back(wr_q[i]);
    obs_done = done_cnt - d0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    checks++;
    if ({bus.ready, bus.RamEnable, bus.done, bus.busy, bus.partial, bus.overflow} !== 6'b0 ||
        bus.word_count !== 16'h0 || bus.memAdress !== 16'h0 || bus.memData !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got rdy=%b en=%b done=%b busy=%b wc=%h adr=%h dat=%h, expected all 0",
               bus.ready, bus.RamEnable, bus.done, bus.busy, bus.word_count, bus.memAdress, bus.memData);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_image_load();
    stim = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
    model(1'b0);
    run_transfer(1'b0, 0, 1'b0, 1'b0);
    checks++;
    if (obs_q.size() != 2 || obs_q[0] !== 32'h0000_1234 || obs_q[1] !== 32'h0001_5678) begin
      errors++;
      $display("[TB] FAIL image_writes: got %0d writes first=%h, expected 2 writes 00001234,00015678",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 32'hx);
    end
    checks++;
    if (bus.word_count !== exp_wc || bus.partial !== exp_partial || bus.overflow !== exp_ovf) begin
      errors++;
      $display("[TB] FAIL image_flags: got wc=%0d p=%b o=%b, expected wc=%0d p=%b o=%b",
               bus.word_count, bus.partial, bus.overflow, exp_wc, exp_partial, exp_ovf);
    end
    checks++;
    if (obs_done != 1 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL image_done: got %0d done pulses busy=%b, expected 1 and 0", obs_done, bus.busy);
    end
  endtask

  task automatic test_filter_gaps();
    stim = '{4'hA, 4'hB, 4'hC, 4'hD};
    model(1'b1);
    run_transfer(1'b1, 2, 1'b0, 1'b0);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== 32'h8000_ABCD || obs_q[0] !== exp_q[0]) begin
      errors++;
      $display("[TB] FAIL filter_write: got %0d writes first=%h, expected 1 write 8000abcd",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 32'hx);
    end
    checks++;
    if (rdy_wr !== 0) begin
      errors++;
      $display("[TB] FAIL ready_in_write: got ready high in %0d write cycles, expected 0", rdy_wr);
    end
    checks++;
    if (bus.word_count !== 16'd1 || bus.partial !== 1'b0 || obs_done != 1) begin
      errors++;
      $display("[TB] FAIL filter_flags: got wc=%0d p=%b done=%0d, expected 1 0 1",
               bus.word_count, bus.partial, obs_done);
    end
  endtask

  task automatic test_partial_word();
    stim = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
    model(1'b0);
    run_transfer(1'b0, 0, 1'b0, 1'b0);
    checks++;
    if (obs_q.size() != 2 || obs_q[0] !== 32'h0000_1234 || obs_q[1] !== 32'h0001_5600) begin
      errors++;
      $display("[TB] FAIL partial_writes: got %0d writes last=%h, expected 00001234,00015600",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : 32'hx);
    end
    checks++;
    if (bus.partial !== 1'b1 || bus.word_count !== 16'd2 || bus.overflow !== 1'b0 || obs_done != 1) begin
      errors++;
      $display("[TB] FAIL partial_flags: got p=%b wc=%0d o=%b done=%0d, expected 1 2 0 1",
               bus.partial, bus.word_count, bus.overflow, obs_done);
    end
  endtask

  task automatic test_overflow();
    stim.delete();
    for (int i = 0; i < 5 * N; i++) stim.push_back(4'((i * 7 + 3) % 16));
    model(1'b0);
    run_transfer(1'b0, 0, 1'b0, 1'b0);
    checks++;
    if (obs_q.size() != DEPTH) begin
      errors++;
      $display("[TB] FAIL ovf_count: got %0d writes, expected %0d", obs_q.size(), DEPTH);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL ovf_write%0d: got %h, expected %h", i,
                 (i < obs_q.size()) ? obs_q[i] : 32'hx, exp_q[i]);
      end
    end
    checks++;
    if (bus.overflow !== 1'b1 || bus.word_count !== 16'd4 || obs_acc != exp_acc || obs_done != 1) begin
      errors++;
      $display("[TB] FAIL ovf_flags: got o=%b wc=%0d acc=%0d done=%0d, expected 1 4 %0d 1",
               bus.overflow, bus.word_count, obs_acc, exp_acc, obs_done);
    end
    bus.load = 1'b1; bus.din_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.ready !== 1'b0 || bus.RamEnable !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_ready: got ready=%b en=%b, expected 0 0", bus.ready, bus.RamEnable);
    end
    bus.load = 1'b0; bus.din_valid = 1'b0;
  endtask

  task automatic test_irq_and_drop();
    stim = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    model(1'b0);
    run_transfer(1'b0, 1, 1'b1, 1'b1);
    checks++;
    if (obs_q.size() != 2 || obs_q[0] !== 32'h0000_1234 || obs_q[1] !== 32'h0001_5000) begin
      errors++;
      $display("[TB] FAIL drop_writes: got %0d writes last=%h, expected 00001234,00015000",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : 32'hx);
    end
    checks++;
    if (bus.partial !== 1'b1 || bus.word_count !== 16'd2 || obs_done != 1 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drop_flags: got p=%b wc=%0d done=%0d busy=%b, expected 1 2 1 0",
               bus.partial, bus.word_count, obs_done, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    bus.cnn = 1'b1; bus.interrupt = 1'b1; bus.load = 1'b1;
    @(posedge clk); #1;
    bus.interrupt = 1'b0; bus.datain = 4'h9; bus.din_valid = 1'b1;
    @(posedge clk); #1;
    bus.datain = 4'h8;
    @(posedge clk); #1;
    bus.din_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_busy: got busy=%b, expected 1", bus.busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus.ready, bus.RamEnable, bus.done, bus.busy, bus.partial, bus.overflow} !== 6'b0 ||
        bus.word_count !== 16'h0 || bus.memAdress !== 16'h0 || bus.memData !== 16'h0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got rdy=%b busy=%b wc=%h adr=%h dat=%h, expected all 0",
               bus.ready, bus.busy, bus.word_count, bus.memAdress, bus.memData);
    end
    bus.load = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    stim = '{4'h1, 4'h2, 4'h3, 4'h4};
    model(1'b0);
    run_transfer(1'b0, 0, 1'b0, 1'b0);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== 32'h0000_1234) begin
      errors++;
      $display("[TB] FAIL after_reset_write: got %0d writes first=%h, expected 00001234",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 32'hx);
    end
  endtask

  task automatic test_random();
    bit c;
    int n, gap;
    for (int it = 0; it < 8; it++) begin
      c   = 1'($urandom_range(0, 1));
      n   = $urandom_range(1, 20);
      gap = $urandom_range(0, 2);
      stim.delete();
      for (int i = 0; i < n; i++) stim.push_back(4'($urandom_range(0, 15)));
      model(c);
      run_transfer(c, gap, 1'($urandom_range(0, 1)), 1'b0);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++;
        $display("[TB] FAIL rand%0d_count: got %0d writes, expected %0d", it, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("[TB] FAIL rand%0d_write%0d: got %h, expected %h", it, i,
                   (i < obs_q.size()) ? obs_q[i] : 32'hx, exp_q[i]);
        end
      end
      checks++;
      if (bus.word_count !== exp_wc || bus.partial !== exp_partial || bus.overflow !== exp_ovf ||
          obs_acc != exp_acc || obs_done != 1) begin
        errors++;
        $display("[TB] FAIL rand%0d_flags: got wc=%0d p=%b o=%b acc=%0d done=%0d, expected %0d %b %b %0d 1",
                 it, bus.word_count, bus.partial, bus.overflow, obs_acc, obs_done,
                 exp_wc, exp_partial, exp_ovf, exp_acc);
      end
    end
  endtask

  initial begin
    bus.interrupt = 1'b0; bus.load = 1'b0; bus.cnn = 1'b0;
    bus.datain = '0; bus.din_valid = 1'b0;
    test_reset();
    test_image_load();
    test_filter_gaps();
    test_partial_word();
    test_overflow();
    test_irq_and_drop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
